// File: rtl/mult_div_pkg.sv
// Shared types for the EX-stage multiply/divide unit: operation codes,
// FSM states and the iteration counter width helper.
package mult_div_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_t;

  typedef enum logic [1:0] {
    OCIOSO,
    CALCULA,
    AJUSTE
  } estado_t;

  function automatic int unsigned largura_cont(input int unsigned largura);
    return $clog2(largura + 1);
  endfunction

endpackage

// File: rtl/unidade_mult_div_if.sv
// Request/response bundle between the EX stage (master) and the
// multiply/divide unit (slave).
interface unidade_mult_div_if
  import mult_div_pkg::*;
#(
  parameter int WIDTH = 32
) ();

  logic             inicio;
  op_t              op;
  logic [WIDTH-1:0] operando_a;
  logic [WIDTH-1:0] operando_b;
  logic             limpar;
  logic             ocupado;
  logic             pronto;
  logic             div_zero;
  logic             parada;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output inicio, op, operando_a, operando_b, limpar,
    input  ocupado, pronto, div_zero, parada, hi, lo
  );

  modport slave (
    input  inicio, op, operando_a, operando_b, limpar,
    output ocupado, pronto, div_zero, parada, hi, lo
  );

endinterface

// File: rtl/unidade_mult_div_passo.sv
// One radix-2 iteration: shift-add multiply step or restoring divide step
// on the shared {upper, lower} accumulator.
module passo_mult_div #(
  parameter int WIDTH = 32
) (
  input  logic               i_modo_div,
  input  logic [2*WIDTH:0]   i_acc,
  input  logic [WIDTH-1:0]   i_operando,
  output logic [2*WIDTH:0]   o_acc
);

  logic [WIDTH:0]   w_soma;
  logic [WIDTH:0]   w_resto_desl;
  logic [WIDTH+1:0] w_dif;
  logic             w_neg;

  always_comb begin
    w_soma       = i_acc[0] ? (i_acc[2*WIDTH:WIDTH] + {1'b0, i_operando})
                            : i_acc[2*WIDTH:WIDTH];
    // Remainder shifted left, pulling in the next dividend bit.
    w_resto_desl = i_acc[2*WIDTH-1:WIDTH-1];
    w_dif        = {1'b0, w_resto_desl} - {2'b00, i_operando};
    w_neg        = w_dif[WIDTH+1];
    if (i_modo_div) begin
      o_acc = {(w_neg ? w_resto_desl : w_dif[WIDTH:0]), i_acc[WIDTH-2:0], ~w_neg};
    end else begin
      o_acc = {1'b0, w_soma, i_acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/unidade_mult_div.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding HI/LO; WIDTH+1 cycle latency,
// single-cycle MTHI/MTLO, flush and stall support for the EX stage.
module unidade_mult_div
  import mult_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic               clock,
  input logic               reset,
  unidade_mult_div_if.slave bus
);

  localparam int CW = largura_cont(WIDTH);
  localparam int AW = 2 * WIDTH + 1;

  estado_t            r_estado;
  logic [CW-1:0]      r_cont;
  logic [AW-1:0]      r_acc;
  logic [WIDTH-1:0]   r_operando;
  logic [WIDTH-1:0]   r_a_bruto;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_modo_div;
  logic               r_sinal_a;
  logic               r_sinal_b;
  logic               r_div_zero_lat;
  logic               r_ocupado;
  logic               r_pronto;
  logic               r_div_zero;

  logic               w_eh_div;
  logic               w_com_sinal;
  logic               w_sinal_a;
  logic               w_sinal_b;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [AW-1:0]      w_acc_prox;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quoc;
  logic [WIDTH-1:0]   w_resto;

  always_comb begin
    w_eh_div    = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
    w_com_sinal = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    w_sinal_a   = w_com_sinal & bus.operando_a[WIDTH-1];
    w_sinal_b   = w_com_sinal & bus.operando_b[WIDTH-1];
    w_mag_a     = w_sinal_a ? -bus.operando_a : bus.operando_a;
    w_mag_b     = w_sinal_b ? -bus.operando_b : bus.operando_b;
  end

  passo_mult_div #(.WIDTH(WIDTH)) u_passo (
    .i_modo_div (r_modo_div),
    .i_acc      (r_acc),
    .i_operando (r_operando),
    .o_acc      (w_acc_prox)
  );

  // Signs are latched as zero for unsigned ops, so the fix-up is a no-op there.
  always_comb begin
    w_prod  = (r_sinal_a ^ r_sinal_b) ? -r_acc[2*WIDTH-1:0] : r_acc[2*WIDTH-1:0];
    w_quoc  = (r_sinal_a ^ r_sinal_b) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    w_resto = r_sinal_a ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado       <= OCIOSO;
      r_cont         <= '0;
      r_acc          <= '0;
      r_operando     <= '0;
      r_a_bruto      <= '0;
      r_hi           <= '0;
      r_lo           <= '0;
      r_modo_div     <= 1'b0;
      r_sinal_a      <= 1'b0;
      r_sinal_b      <= 1'b0;
      r_div_zero_lat <= 1'b0;
      r_ocupado      <= 1'b0;
      r_pronto       <= 1'b0;
      r_div_zero     <= 1'b0;
    end else begin
      r_pronto   <= 1'b0;
      r_div_zero <= 1'b0;
      if (bus.limpar) begin
        r_estado  <= OCIOSO;
        r_cont    <= '0;
        r_ocupado <= 1'b0;
      end else begin
        case (r_estado)
          OCIOSO: begin
            if (bus.inicio) begin
              case (bus.op)
                OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                  r_estado       <= CALCULA;
                  r_ocupado      <= 1'b1;
                  r_cont         <= '0;
                  r_modo_div     <= w_eh_div;
                  r_sinal_a      <= w_sinal_a;
                  r_sinal_b      <= w_sinal_b;
                  r_a_bruto      <= bus.operando_a;
                  r_div_zero_lat <= w_eh_div && (bus.operando_b == '0);
                  r_operando     <= w_eh_div ? w_mag_b : w_mag_a;
                  r_acc          <= {{(WIDTH+1){1'b0}}, (w_eh_div ? w_mag_a : w_mag_b)};
                end
                OP_MTHI: begin
                  r_hi     <= bus.operando_a;
                  r_pronto <= 1'b1;
                end
                OP_MTLO: begin
                  r_lo     <= bus.operando_a;
                  r_pronto <= 1'b1;
                end
                default: ;
              endcase
            end
          end
          CALCULA: begin
            r_acc  <= w_acc_prox;
            r_cont <= r_cont + 1'b1;
            if (r_cont == CW'(WIDTH - 1)) begin
              r_estado <= AJUSTE;
            end
          end
          AJUSTE: begin
            if (r_div_zero_lat) begin
              r_hi       <= r_a_bruto;
              r_lo       <= '1;
              r_div_zero <= 1'b1;
            end else if (r_modo_div) begin
              r_hi <= w_resto;
              r_lo <= w_quoc;
            end else begin
              r_hi <= w_prod[2*WIDTH-1:WIDTH];
              r_lo <= w_prod[WIDTH-1:0];
            end
            r_pronto  <= 1'b1;
            r_ocupado <= 1'b0;
            r_estado  <= OCIOSO;
          end
          default: r_estado <= OCIOSO;
        endcase
      end
    end
  end

  assign bus.ocupado  = r_ocupado;
  assign bus.pronto   = r_pronto;
  assign bus.div_zero = r_div_zero;
  assign bus.hi       = r_hi;
  assign bus.lo       = r_lo;
  assign bus.parada   = bus.inicio & r_ocupado;

endmodule

// File: tb/tb_unidade_mult_div.sv
// Bench for unidade_mult_div: table of MULT/DIV vectors plus hand sequences
// for back-to-back issue, stall, flush and reset; results scored on pronto.
module tb_unidade_mult_div;
  import mult_div_pkg::*;

  localparam int W = 32;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  unidade_mult_div_if #(.WIDTH(W)) bus ();
  unidade_mult_div #(.WIDTH(W)) dut (.clock(clock), .reset(reset), .bus(bus));

  typedef struct {
    op_t          op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    string        nome;
  } vetor_t;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    string        nome;
  } esperado_t;

  esperado_t    sb[$];
  vetor_t       tab [13];
  int           n_checks = 0;
  int           n_erros  = 0;
  logic [W-1:0] m_hi;
  logic [W-1:0] m_lo;

  task automatic checar(input string nome, input logic [63:0] atual, input logic [63:0] req);
    n_checks++;
    if (atual !== req) begin
      n_erros++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nome, atual, req);
    end
  endtask

  task automatic ciclo();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard: every pronto pulse consumes one expected result.
  always @(negedge clock) begin : monitor
    esperado_t e;
    if (reset !== 1'b1 && bus.pronto === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_erros++;
        $display("FAIL unexpected_pronto: got pronto=1 (hi=0x%0h lo=0x%0h), required no pronto", bus.hi, bus.lo);
      end else begin
        e = sb.pop_front();
        $display("txn %s: hi=0x%0h lo=0x%0h div_zero=%0b", e.nome, bus.hi, bus.lo, bus.div_zero);
        checar({e.nome, ".hi"}, bus.hi, e.hi);
        checar({e.nome, ".lo"}, bus.lo, e.lo);
        checar({e.nome, ".div_zero"}, bus.div_zero, e.dz);
      end
    end else if (reset !== 1'b1 && bus.div_zero === 1'b1) begin
      n_checks++;
      n_erros++;
      $display("FAIL div_zero_alone: got div_zero=1 with pronto=0, required none");
    end
  end

  task automatic executar(input op_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                          input logic dz, input string nome, input int lat_req);
    esperado_t e;
    int lat;
    int n_oc;
    e.hi = exp_hi; e.lo = exp_lo; e.dz = dz; e.nome = nome;
    sb.push_back(e);
    bus.op = op; bus.operando_a = a; bus.operando_b = b; bus.inicio = 1'b1;
    ciclo();
    bus.inicio = 1'b0;
    lat = 0;
    n_oc = 0;
    while (bus.pronto !== 1'b1 && lat < 100) begin
      if (bus.ocupado === 1'b1) n_oc++;
      ciclo();
      lat++;
    end
    if (bus.pronto !== 1'b1) begin
      n_checks++;
      n_erros++;
      $display("FAIL %s.timeout: got no pronto in %0d cycles, required pronto", nome, lat);
      sb.delete();
    end else begin
      checar({nome, ".latency"}, lat, lat_req);
      checar({nome, ".busy_cycles"}, n_oc, lat_req);
      checar({nome, ".ocupado_at_pronto"}, bus.ocupado, 1'b0);
    end
    m_hi = exp_hi;
    m_lo = exp_lo;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tab[0]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, "mult_minxmin"};
    tab[1]  = '{OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, "mult_m1xm1"};
    tab[2]  = '{OP_MULT,  32'h00003039, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFF9F8E, 1'b0, "mult_12345xm2"};
    tab[3]  = '{OP_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0, "multu_2p16sq"};
    tab[4]  = '{OP_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0, "mult_maxsq"};
    tab[5]  = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0, "divu_100_7"};
    tab[6]  = '{OP_DIV,   32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFF2, 1'b0, "div_m100_7"};
    tab[7]  = '{OP_DIV,   32'd100,      32'hFFFFFFF9, 32'd2,        32'hFFFFFFF2, 1'b0, "div_100_m7"};
    tab[8]  = '{OP_DIV,   32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd14,       1'b0, "div_m100_m7"};
    tab[9]  = '{OP_DIVU,  32'd7,        32'd0,        32'd7,        32'hFFFFFFFF, 1'b1, "divu_7_0"};
    tab[10] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, "div_min_m1"};
    tab[11] = '{OP_DIVU,  32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 1'b0, "divu_max_1"};
    tab[12] = '{OP_DIVU,  32'd5,        32'd10,       32'd5,        32'd0,        1'b0, "divu_5_10"};

    // Reset held two cycles while a MULT is requested.
    reset = 1'b1;
    bus.inicio = 1'b1; bus.op = OP_MULT; bus.operando_a = 32'd5; bus.operando_b = 32'd3;
    bus.limpar = 1'b0;
    repeat (2) ciclo();
    reset = 1'b0;
    bus.inicio = 1'b0;
    checar("reset.hi", bus.hi, 32'h0);
    checar("reset.lo", bus.lo, 32'h0);
    checar("reset.ocupado", bus.ocupado, 1'b0);
    checar("reset.pronto", bus.pronto, 1'b0);
    checar("reset.div_zero", bus.div_zero, 1'b0);
    ciclo();
    checar("reset.no_accept", bus.ocupado, 1'b0);
    m_hi = '0;
    m_lo = '0;

    executar(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, "multu_max", W + 1);
    ciclo();
    checar("multu_max.pronto_one_cycle", bus.pronto, 1'b0);

    // DIV issued in the same cycle the MULT's pronto is high.
    executar(OP_MULT, 32'hFFFFFFF9, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, "mult_m7x3", W + 1);
    executar(OP_DIV,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, "div_m7_2_b2b", W + 1);

    for (int i = 0; i < 13; i++) begin
      executar(tab[i].op, tab[i].a, tab[i].b, tab[i].hi, tab[i].lo, tab[i].dz, tab[i].nome, W + 1);
    end

    // Undefined opcode: accepted silently, nothing changes.
    bus.op = op_t'(3'd6); bus.operando_a = 32'h5555; bus.inicio = 1'b1;
    ciclo();
    bus.inicio = 1'b0;
    repeat (3) ciclo();
    checar("noop.ocupado", bus.ocupado, 1'b0);
    checar("noop.hi", bus.hi, m_hi);
    checar("noop.lo", bus.lo, m_lo);

    // Stall then flush of an in-flight MULT.
    executar(OP_MTHI, 32'h1234, 32'd0, 32'h1234, m_lo, 1'b0, "mthi_1234", 0);
    ciclo();
    bus.op = OP_MULT; bus.operando_a = 32'd5; bus.operando_b = 32'd5; bus.inicio = 1'b1;
    #1;
    checar("stall.parada_idle", bus.parada, 1'b0);
    ciclo();
    bus.inicio = 1'b0;
    repeat (9) ciclo();
    bus.op = OP_MTLO; bus.operando_a = 32'd9; bus.inicio = 1'b1;
    #1;
    checar("stall.parada", bus.parada, 1'b1);
    ciclo();
    bus.inicio = 1'b0;
    checar("stall.still_busy", bus.ocupado, 1'b1);
    checar("stall.lo_unchanged", bus.lo, m_lo);
    ciclo();
    bus.limpar = 1'b1;
    ciclo();
    bus.limpar = 1'b0;
    checar("flush.ocupado", bus.ocupado, 1'b0);
    checar("flush.hi", bus.hi, 32'h1234);
    repeat (40) ciclo();
    checar("flush.hi_late", bus.hi, 32'h1234);
    checar("flush.lo_late", bus.lo, m_lo);
    executar(OP_MTLO, 32'd9, 32'd0, 32'h1234, 32'd9, 1'b0, "mtlo_reissue", 0);

    // limpar wins over a simultaneous inicio.
    ciclo();
    bus.op = OP_MTHI; bus.operando_a = 32'hAAAA; bus.inicio = 1'b1; bus.limpar = 1'b1;
    ciclo();
    bus.inicio = 1'b0; bus.limpar = 1'b0;
    ciclo();
    checar("flush_vs_start.hi", bus.hi, 32'h1234);

    // Reset in the middle of an operation.
    bus.op = OP_MULTU; bus.operando_a = 32'd3; bus.operando_b = 32'd4; bus.inicio = 1'b1;
    ciclo();
    bus.inicio = 1'b0;
    repeat (5) ciclo();
    reset = 1'b1;
    ciclo();
    reset = 1'b0;
    checar("midreset.hi", bus.hi, 32'h0);
    checar("midreset.lo", bus.lo, 32'h0);
    checar("midreset.ocupado", bus.ocupado, 1'b0);
    repeat (40) ciclo();
    checar("midreset.lo_late", bus.lo, 32'h0);

    repeat (2) ciclo();
    checar("scoreboard.drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_erros, n_checks);
    $finish;
  end

endmodule

// File: doc/unidade_mult_div.md
# unidade_mult_div

Parametrised iterative multiply/divide unit for the EX stage of the five-stage pipeline. It holds the architectural HI/LO registers and executes MULT/MULTU/DIV/DIVU in WIDTH+1 cycles using a radix-2 shift-add multiplier and a restoring divider. It also performs single-cycle MTHI/MTLO. It exposes a start/busy/done handshake and a stall request, so the hazard logic can freeze IF/ID/EX, and it accepts a flush so a branch taken in MEM can kill an in-flight operation.

## Interface
Parameters:
- WIDTH, 32, operand and HI/LO width (≥4, even)

Ports:
- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state
- inicio  in  1  start request, sampled each rising edge
- op  in  3  operation code (package enum)
- operando_a  in  WIDTH  rs value (dividend / multiplicand / MTHI-MTLO source)
- operando_b  in  WIDTH  rt value (divisor / multiplier)
- limpar  in  1  flush: abort in-flight operation
- ocupado  out  1  operation in progress (registered)
- pronto  out  1  one-cycle pulse: HI/LO just updated by MULT/DIV/MT*
- div_zero  out  1  one-cycle pulse with pronto when the divisor was zero
- parada  out  1  combinational: inicio && ocupado
- hi, lo  out  WIDTH  architectural HI/LO registers

## Operation
- op encoding: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others are a no-op; a request with one of these codes is still accepted and pronto stays low.
- Acceptance: at a rising edge with inicio=1, ocupado=0, limpar=0, reset=0.
- States:
  - OCIOSO → CALCULA on accepted MULT/DIV class.
  - CALCULA: counter counts WIDTH iterations, then → AJUSTE.
  - AJUSTE: applies sign fix, writes HI/LO, pulses pronto, → OCIOSO.
- MTHI/MTLO: stay in OCIOSO. hi (resp. lo) ← operando_a at the accepting edge; pronto pulses the next cycle.
- Signed operations latch magnitudes at acceptance, together with sign_a and sign_b.
- Multiply: full 2·WIDTH product. For MULT, negate the product if sign_a^sign_b. hi=upper half, lo=lower half.
- Divide: lo=quotient, hi=remainder.
  - DIV: quotient negated if sign_a^sign_b; remainder takes the sign of the dividend (truncating division).
  - Most-negative / −1 gives lo=most-negative, hi=0, with no other flag.
- Divisor zero (detected at acceptance): latency is unchanged.
  - Result is lo=all ones, hi=operando_a as latched.
  - div_zero pulses with pronto.
- inicio while ocupado: ignored, operands are not latched, parada=1 that cycle.
- limpar=1 at any edge:
  - State → OCIOSO, counter cleared, hi/lo unchanged, no pronto.
  - limpar overrides a simultaneous inicio: the request is not accepted.
- reset: state OCIOSO; hi, lo, ocupado, pronto, div_zero = 0. reset mid-operation discards the operation.

## Timing
- Acceptance edge E0 for MULT/DIV class:
  - ocupado=1 in the cycles after E0 … E0+WIDTH.
  - hi/lo update at edge E0+WIDTH+1.
  - pronto/div_zero are high in the cycle after E0+WIDTH+1; ocupado=0 in that cycle.
  - Busy window is WIDTH+1 cycles (33 for WIDTH=32).
- A new inicio is accepted in the same cycle that pronto is high (back-to-back, no dead cycle).
- MTHI/MTLO: hi/lo update at E0; pronto in the next cycle; ocupado never asserts.
- parada is purely combinational and has no registered delay.
- hi/lo are only written at the AJUSTE exit or the MT* edge. Readers (MFHI/MFLO) must stall on ocupado.

## Structure
- Package mult_div_pkg:
  - op enum (OP_MULT … OP_MTLO).
  - state enum (OCIOSO, CALCULA, AJUSTE).
  - Counter width function clog2(WIDTH+1).
- Sub-module passo_mult_div: combinational single iteration step, instantiated once.
  - Multiply mode: conditional add of the multiplicand to the upper accumulator, then shift right.
  - Divide mode: shift left, trial subtract, restore on negative, shift in the quotient bit.
- Top module holds the FSM, counter, operand/sign latches, accumulator (2·WIDTH+1 bits), and HI/LO.

## Test plan
- Reset:
  - Stimulus: assert reset 2 cycles with inicio=1, op=MULT.
  - Required response: hi=lo=0, ocupado=pronto=div_zero=0, no operation accepted.
- MULTU:
  - Stimulus: 0xFFFFFFFF × 0xFFFFFFFF.
  - Required response: ocupado high exactly 33 cycles; at edge E0+33, hi=0xFFFFFFFE, lo=0x00000001; pronto for one cycle.
- MULT, then DIV back-to-back in the pronto cycle:
  - Stimulus: MULT −7 × 3, then DIV −7 / 2.
  - Required response: MULT gives hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIV gives lo=0xFFFFFFFD, hi=0xFFFFFFFF; its pronto comes exactly 33 edges after the first pronto.
- Division corner cases:
  - Stimulus: DIVU 7 / 0.
  - Required response: lo=0xFFFFFFFF, hi=7, div_zero and pronto pulse together.
  - Stimulus: DIV 0x80000000 / 0xFFFFFFFF.
  - Required response: lo=0x80000000, hi=0, div_zero=0.
- Flush and stall:
  - Stimulus: MTHI 0x1234, then MULT 5 × 5; at cycle 10 raise inicio (MTLO 9).
  - Required response: parada=1 and the MTLO is ignored.
  - Stimulus: raise limpar at cycle 12.
  - Required response: ocupado=0 the next cycle, hi stays 0x1234, no pronto.
  - Stimulus: MTLO 9 reissued.
  - Required response: accepted immediately, lo=9.
